// File: rtl/latch_seq_pkg.sv
// Shared types and default parameters for the latch write sequencer.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NADDR    = 4;
  localparam int DEF_HOLD_CYC = 1;

  // Wide enough for the largest legal hold length (15 cycles).
  localparam int HOLD_CW = 4;

endpackage

// File: rtl/arb2.sv
// Two-requester arbiter with a one-hot grant.
// Optional macro LATCH_SEQ_ROUNDROBIN_EN: when defined, contention is resolved
// round-robin using a one-bit pointer; otherwise requester 0 always wins
// and the pointer, clock and reset ports do not exist.
module arb2 (
  input  logic [1:0] req,
  output logic [1:0] grant
`ifdef LATCH_SEQ_ROUNDROBIN_EN
  ,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv
`endif
);

`ifdef LATCH_SEQ_ROUNDROBIN_EN
  // ptr high means requester 1 currently has priority.
  logic ptr;

  // Pointer moves away from whoever was just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= grant[0];
    end
  end

  // Grant the single requester, or the prioritized one under contention.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
`else
  // Fixed priority: requester 0 always wins contention.
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/latch_write_seq.sv
// Latch write sequencer: arbitrates two requesters and drives one latch word
// through SETUP (data valid, gate closed), GATE (one-cycle gate pulse) and
// HOLD (data held for HOLD_CYC cycles after the gate closes).
// Optional macro LATCH_SEQ_ROUNDROBIN_EN selects round-robin arbitration.
module latch_write_seq
  import latch_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NADDR    = DEF_NADDR,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  localparam int AW      = $clog2(NADDR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] lat_d,
  output logic [NADDR-1:0] lat_en,
  output logic             busy
);

  localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(HOLD_CYC - 1);

  state_t               state_q;
  state_t               next_state;
  logic [HOLD_CW-1:0]   hold_cnt;
  logic [HOLD_CW-1:0]   hold_nxt;
  logic [AW-1:0]        cap_addr;
  logic                 cap_sel;
  logic [1:0]           grant;
  logic                 accept;
  logic [1:0]           gnt_nxt;
  logic [1:0]           done_nxt;
  logic [NADDR-1:0]     lat_en_nxt;

  // A request is only taken while idle; this also advances the arbiter.
  assign accept = (state_q == IDLE) && (req != 2'b00);
  assign busy   = (state_q != IDLE);

  arb2 u_arb (
    .req   (req),
    .grant (grant)
`ifdef LATCH_SEQ_ROUNDROBIN_EN
    ,
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (accept)
`endif
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic; the hold counter restarts from zero on entry to HOLD.
  always_comb begin
    next_state = state_q;
    hold_nxt   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
        end
      end
      SETUP: next_state = GATE;
      GATE:  next_state = HOLD;
      HOLD: begin
        hold_nxt = hold_cnt + HOLD_CW'(1);
        if (hold_cnt == HOLD_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, so every output leaves a flop.
  always_comb begin
    gnt_nxt    = accept ? grant : 2'b00;
    lat_en_nxt = '0;
    if (state_q == SETUP) begin
      lat_en_nxt[cap_addr] = 1'b1;
    end
    done_nxt = 2'b00;
    if ((next_state == HOLD) && (hold_nxt == HOLD_LAST)) begin
      done_nxt = {cap_sel, ~cap_sel};
    end
  end

  // Capture registers, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_sel  <= 1'b0;
      lat_d    <= '0;
      hold_cnt <= '0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      lat_en   <= '0;
    end else begin
      if (accept) begin
        cap_sel  <= grant[1];
        cap_addr <= grant[1] ? addr1 : addr0;
        lat_d    <= grant[1] ? data1 : data0;
      end
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      lat_en   <= lat_en_nxt;
    end
  end

endmodule

// File: doc/latch_write_seq.md
LATCH_WRITE_SEQ -- requirements
Module: latch_write_seq

Interface
REQ-001 Parameter WIDTH, default 8: data width of each latch word.
REQ-002 Parameter NADDR, default 4: number of latch words; power of two, at least 2; AW = log2(NADDR).
REQ-003 Parameter HOLD_CYC, default 1: number of cycles data is held after the gate closes; range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req  input  2  write request per requester; bit i belongs to requester i.
REQ-007 addr0, addr1  input  AW each  target word for requester 0 and requester 1.
REQ-008 data0, data1  input  WIDTH each  write data for requester 0 and requester 1.
REQ-009 gnt  output  2  registered one-hot grant; high for one cycle.
REQ-010 done  output  2  registered one-hot completion pulse; high for one cycle.
REQ-011 lat_d  output  WIDTH  data bus driving the D inputs of all latch words.
REQ-012 lat_en  output  NADDR  one-hot gate (clk/enable) per latch word; all-zero when idle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, GATE and HOLD.
REQ-015 In IDLE with req nonzero, the next edge SHALL capture the winner's addr/data and go to SETUP, with gnt[winner]=1 for the SETUP cycle only.
REQ-016 In SETUP, lat_d SHALL equal the captured data and lat_en SHALL be all-zero; the next state SHALL be GATE.
REQ-017 In GATE, lat_en[captured addr] SHALL be 1 and all other bits 0, for exactly one cycle; lat_d SHALL be unchanged.
REQ-018 In HOLD, lat_en SHALL be all-zero and lat_d unchanged for HOLD_CYC cycles, then the FSM SHALL return to IDLE.
REQ-019 done[winner] SHALL be 1 during the last HOLD cycle.
REQ-020 Latency from the edge that samples req to the done pulse SHALL be 2+HOLD_CYC cycles.
REQ-021 IDLE SHALL last at least one cycle between transactions; requests SHALL be sampled only in IDLE.
REQ-022 A requester SHALL hold req, addr and data stable until it sees gnt, and SHALL deassert req no later than the cycle after done.
REQ-023 When both requesters request in the same IDLE cycle, exactly one SHALL be granted, according to REQ-030/031; the loser remains pending.
REQ-024 lat_en SHALL come directly from registers and SHALL be glitch-free; at most one bit SHALL be high at any time.
REQ-025 lat_d SHALL keep its last value in IDLE.

Reset
REQ-026 While rst_n=0, outputs SHALL be asynchronously forced as follows: lat_en=0, lat_d=0, gnt=0, done=0, busy=0.
REQ-027 During reset, the FSM SHALL go to IDLE and the round-robin pointer SHALL be set so that requester 0 has priority.
REQ-028 Reset asserted mid-transaction, including during GATE, SHALL abort the transaction immediately with no done pulse; the requester SHALL re-request after reset.
REQ-029 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With LATCH_SEQ_ROUNDROBIN_EN defined, contention SHALL be resolved round-robin: the requester not granted last wins, and the pointer updates on each grant.
REQ-031 Without LATCH_SEQ_ROUNDROBIN_EN, requester 0 SHALL always win contention, and no pointer register SHALL exist.

Structure
REQ-032 Package latch_seq_pkg SHALL hold the state enum (IDLE, SETUP, GATE, HOLD) and the default values of WIDTH, NADDR and HOLD_CYC.
REQ-033 Arbitration SHALL be a sub-module, arb2: 2-bit req in, one-hot grant out, with the pointer present only under the macro.
REQ-034 The top level SHALL contain the FSM, the capture registers, the HOLD counter and the lat_en decode.

Verification
REQ-035 Single write: req=01, addr0=2, data0=0xA5 -> gnt=01 at cycle 1; lat_d=0xA5 from cycle 1; lat_en=0100 at cycle 2 only; done=01 at cycle 3 (HOLD_CYC=1).
REQ-036 Contention with the macro on: req=11 held, requester 0 served first -> the next grant goes to requester 1; with the macro off, requester 0 is granted again whenever it re-requests.
REQ-037 Back-to-back: requester 1 reasserts req in the cycle after done -> IDLE is observed for at least one cycle, and gnt=10 appears exactly 1 cycle later.
REQ-038 Reset during GATE: rst_n=0 mid-cycle -> lat_en=0 without waiting for an edge, no done pulse, busy=0.
REQ-039 HOLD_CYC=3: lat_d stable and lat_en=0 for 3 cycles after GATE; done arrives at latency 5.
REQ-040 Assertions on all runs: lat_en is always one-hot or zero, gnt and done are never both bits high, and lat_en is never high outside GATE.
